// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: fixed priority for the CPU port (port 0), bounded-wait
// starvation guard for port 1, optional owner lock, and a 1-cycle read-return path.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    // Ownership state: free, or locked to one of the two ports.
    typedef enum logic [1:0] {
        ARB_FREE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    arb_state_t        state, state_d;
    logic              owner, owner_d;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_port_q, rd_port_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic lock_q;
    logic owner_req;
    logic gnt_lock;

    assign lock_q    = (state != ARB_FREE);
    assign owner_req = owner ? m1_req : m0_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ARB_FREE;
            owner     <= 1'b0;
            wait_cnt  <= '0;
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            wait_cnt  <= wait_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    // Grant selection and next-state for lock, wait counter and read tag.
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        gnt_lock  = 1'b0;
        state_d   = state;
        owner_d   = owner;
        wait_d    = wait_cnt;
        rd_pend_d = 1'b0;
        rd_port_d = rd_port_q;

        if (!reset) begin
            if (lock_q && owner_req) begin
                m0_gnt = ~owner;
                m1_gnt = owner;
            end else if ((wait_cnt == WAIT_LIMIT) && m1_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end

        if (m0_gnt || m1_gnt) begin
            gnt_lock = m1_gnt ? m1_lock : m0_lock;
            if (gnt_lock) begin
                owner_d = m1_gnt;
                state_d = m1_gnt ? ARB_LOCK1 : ARB_LOCK0;
            end else begin
                state_d = ARB_FREE;
            end
        end else if (lock_q && !owner_req) begin
            state_d = ARB_FREE;
        end

        // A denied port-1 request ages toward the forced grant; anything else restarts it.
        if (m1_req && !m1_gnt) begin
            wait_d = (wait_cnt >= WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt + WAIT_W'(1);
        end else begin
            wait_d = '0;
        end

        if ((m0_gnt && !m0_we) || (m1_gnt && !m1_we)) begin
            rd_pend_d = 1'b1;
            rd_port_d = m1_gnt;
        end
    end

    assign mem_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign mem_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);

    assign m0_rvalid = rd_pend_q & ~rd_port_q;
    assign m1_rvalid = rd_pend_q &  rd_port_q;

    // Per-port read data capture; the live memory word is forwarded in the rvalid cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (m0_rvalid) rdata0_q <= mem_rdata;
            if (m1_rvalid) rdata1_q <= mem_rdata;
        end
    end

    assign m0_rdata = m0_rvalid ? mem_rdata : rdata0_q;
    assign m1_rdata = m1_rvalid ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic checked
// against a rule-level reference model with its own copy of memory.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned N_WORDS  = 256;

    logic              clock;
    logic              reset;
    logic              m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory seen by the DUT: registered read, one-cycle latency.
    logic [DATA_W-1:0] env_mem [N_WORDS];
    initial mem_rdata = '0;
    always @(posedge clock) begin
        if (mem_we) env_mem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= env_mem[mem_addr[9:2]];
    end

    typedef struct {
        logic        g0, g1, we;
        logic [31:0] addr, wdata;
        logic        rv0, rv1;
        logic [31:0] rd0, rd1;
    } cyc_exp_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    cyc_exp_t cyc_q[$];
    rd_exp_t  rd_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] ref_mem [N_WORDS];
    int          lock_own = -1;
    int          wait_n = 0;
    int          pend = -1;
    logic [31:0] pend_data;
    logic [31:0] last_rd [2];
    int          last_g = -1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic step(input logic r0, input logic w0, input logic l0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic r1, input logic w1, input logic l1,
                        input logic [31:0] a1, input logic [31:0] d1);
        int          g;
        logic [1:0]  rq;
        logic [31:0] aa;
        logic        lk;
        cyc_exp_t    e;
        rd_exp_t     r;
        @(posedge clock); #1;
        reset = 1'b0;
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        rq = {r1, r0};
        g = -1;
        if (lock_own >= 0 && rq[lock_own]) g = lock_own;
        else if (wait_n >= int'(MAX_WAIT) && r1) g = 1;
        else if (r0) g = 0;
        else if (r1) g = 1;
        e.g0    = (g == 0);
        e.g1    = (g == 1);
        e.we    = (g == 0) ? w0 : ((g == 1) ? w1 : 1'b0);
        e.addr  = (g == 1) ? a1 : a0;
        e.wdata = (g == 1) ? d1 : d0;
        e.rv0   = (pend == 0);
        e.rv1   = (pend == 1);
        e.rd0   = (pend == 0) ? pend_data : last_rd[0];
        e.rd1   = (pend == 1) ? pend_data : last_rd[1];
        cyc_q.push_back(e);
        if (pend >= 0) last_rd[pend] = pend_data;
        pend = -1;
        if (g >= 0) begin
            aa = e.addr;
            if (e.we) begin
                ref_mem[aa[9:2]] = e.wdata;
            end else begin
                pend = g;
                pend_data = ref_mem[aa[9:2]];
                r.port = g; r.data = pend_data; r.due = cyc + 1;
                rd_q.push_back(r);
            end
            lk = (g == 1) ? l1 : l0;
            lock_own = lk ? g : -1;
        end else if (lock_own >= 0 && !rq[lock_own]) begin
            lock_own = -1;
        end
        if (r1 && g != 1) wait_n = (wait_n + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : wait_n + 1;
        else wait_n = 0;
        last_g = g;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        cyc_exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            reset = 1'b1;
            m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
            m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
            lock_own = -1; wait_n = 0; pend = -1; last_g = -1;
            last_rd[0] = '0; last_rd[1] = '0;
            rd_q.delete();
            e = '{g0: 0, g1: 0, we: 0, addr: 0, wdata: 0, rv0: 0, rv1: 0, rd0: 0, rd1: 0};
            cyc_q.push_back(e);
        end
    endtask

    // Monitor: per-cycle grant/memory/rdata checks and read-return scoreboard.
    initial begin
        cyc_exp_t e;
        rd_exp_t  r;
        forever begin
            @(negedge clock);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("m0_gnt", m0_gnt, e.g0);
                check("m1_gnt", m1_gnt, e.g1);
                check("mem_we", mem_we, e.we);
                check("mem_addr", mem_addr, e.addr);
                if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                check("m0_rvalid", m0_rvalid, e.rv0);
                check("m1_rvalid", m1_rvalid, e.rv1);
                check("m0_rdata", m0_rdata, e.rd0);
                check("m1_rdata", m1_rdata, e.rd1);
            end
            if (m0_rvalid || m1_rvalid) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rvalid_unexpected: got m0=%0b m1=%0b expected none (cycle %0d)",
                             m0_rvalid, m1_rvalid, cyc);
                end else begin
                    r = rd_q.pop_front();
                    check("rd_port", m1_rvalid, r.port == 1);
                    check("rd_data", m1_rvalid ? m1_rdata : m0_rdata, r.data);
                    check("rd_due", cyc, r.due);
                end
            end
        end
    end

    logic        cr [2];
    logic        cw [2];
    logic        cl [2];
    logic [31:0] ca [2];
    logic [31:0] cd [2];

    initial begin
        for (int i = 0; i < int'(N_WORDS); i++) begin
            env_mem[i] = 32'h5A00_0000 ^ (i * 32'h0101_0107);
            ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0101_0107);
        end
        last_rd[0] = '0; last_rd[1] = '0; pend_data = '0;
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
        do_reset(2);

        // Port 0 read of 0x10, returned next cycle
        step(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        idle();

        // Continuous contention: forced port-1 grant every fifth cycle
        for (int i = 0; i < 11; i++) step(1, 0, 0, 32'h100, 0, 1, 0, 0, 32'h104, 0);
        idle();

        // Port-0 lock for three transfers blocks port 1, which wins right after release
        step(1, 0, 1, 32'h40, 0, 1, 0, 0, 32'h80, 0);
        step(1, 0, 1, 32'h44, 0, 1, 0, 0, 32'h80, 0);
        step(1, 0, 1, 32'h48, 0, 1, 0, 0, 32'h80, 0);
        step(1, 0, 0, 32'h4C, 0, 1, 0, 0, 32'h80, 0);
        step(1, 0, 0, 32'h50, 0, 1, 0, 0, 32'h80, 0);
        idle();

        // Port-1 write followed immediately by a port-0 read of the same word
        step(0, 0, 0, 0, 0, 1, 1, 0, 32'h20, 32'hDEADBEEF);
        step(1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        idle();

        // Alternating reads
        step(1, 0, 0, 32'h4, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h8, 0);
        step(1, 0, 0, 32'hC, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Port-1 read, then reset lands in the cycle its data would return
        step(0, 0, 0, 0, 0, 1, 0, 1, 32'h30, 0);
        do_reset(2);
        idle();

        // Random traffic honouring the hold-until-granted rule
        for (int p = 0; p < 2; p++) begin
            cr[p] = 0; cw[p] = 0; cl[p] = 0; ca[p] = '0; cd[p] = '0;
        end
        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (cr[p] && last_g != p) begin
                    if ($urandom_range(0, 9) == 0) cr[p] = 1'b0;
                end else begin
                    cr[p] = ($urandom_range(0, 99) < 55);
                    cw[p] = ($urandom_range(0, 2) == 0);
                    cl[p] = ($urandom_range(0, 4) == 0);
                    ca[p] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                    cd[p] = $urandom;
                end
            end
            step(cr[0], cw[0], cl[0], ca[0], cd[0], cr[1], cw[1], cl[1], ca[1], cd[1]);
        end
        idle();
        idle();
        idle();

        @(negedge clock); #1;
        check("reads_drained", rd_q.size(), 0);
        check("cycles_drained", cyc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory port between the CPU load/store path (port 0) and a secondary bus master such as a display-refresh or debug-loader engine (port 1). Port 0 has fixed priority; port 1 is protected from starvation by a wait counter that forces one grant after a bounded wait. An optional lock lets the current owner keep the port for back-to-back transfers. The block sits between the masters and the memory/IO hub, and drives the memory address, write-data and write-enable lines.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_WAIT`, default 4: number of consecutive denied cycles of port 1 that forces a port-1 grant (1..15).
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m0_req` in 1: port 0 request; `m0_we`, `m0_addr`, `m0_wdata` and `m0_lock` are held stable while `m0_req`=1 and `m0_gnt`=0.
- `m0_we` in 1: port 0 write (1) / read (0).
- `m0_lock` in 1: port 0 requests to keep ownership after this transfer.
- `m0_addr` in ADDR_W: port 0 address.
- `m0_wdata` in DATA_W: port 0 write data.
- `m0_gnt` out 1: port 0 transfer accepted this cycle.
- `m0_rvalid` out 1: `m0_rdata` holds read data of the port-0 read granted in the previous cycle.
- `m0_rdata` out DATA_W: port 0 read data.
- `m1_req`, `m1_we`, `m1_lock`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as port 0, for port 1.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_we` out 1: memory write strobe.
- `mem_rdata` in DATA_W: memory read data, valid one cycle after the address is presented.

## Operation
- A transfer occurs on a rising edge where `mX_req`=1 and `mX_gnt`=1. At most one `gnt` is high in any cycle.
- Grants are combinational from the current requests and the registered state (`owner`, `lock_q`, `wait_cnt`).
- The memory side muxes the granted port's address and write data. `mem_we` = granted `we`. When there is no grant: `mem_we`=0, address/data = port 0 fields.
- Grant priority, evaluated in this order:
  1. `lock_q`=1 and the locked owner requests: the owner is granted.
  2. `wait_cnt` = `MAX_WAIT` and `m1_req`=1: port 1 is granted.
  3. `m0_req`=1: port 0 is granted.
  4. `m1_req`=1: port 1 is granted.
- `lock_q` is set when a granted transfer has `lock`=1, and `owner` is set to that port.
  - `lock_q` clears on a granted transfer with `lock`=0, or on the first cycle the owner's `req` is 0.
  - While the lock is held, the other port is denied.
- `wait_cnt` (4 bits):
  - Increments, saturating at `MAX_WAIT`, on each cycle with `m1_req`=1 and `m1_gnt`=0.
  - Clears on an `m1` grant or when `m1_req`=0.
- Reads: on a read grant, a 1-bit registered tag records the port. The next cycle:
  - that port's `rvalid`=1;
  - its `rdata` = `mem_rdata`, registered in that port's `rdata`, which holds until that port's next read completes.
- Writes produce no `rvalid`.

## Timing
- Reset values: `lock_q`=0, `owner`=0, `wait_cnt`=0, `m0_rvalid`=`m1_rvalid`=0, `m0_rdata`=`m1_rdata`=0.
  - While `reset`=1: both `gnt`=0, `mem_we`=0.
- Grant latency is 0 cycles from `req` when uncontested. Read data latency is 1 cycle after the grant edge.
- Back-to-back grants to alternating ports are allowed every cycle. `rvalid` pulses are 1 cycle each and never overlap.
- Worst-case port-1 wait without lock is `MAX_WAIT` cycles. With a port-0 lock held, the wait is unbounded until the lock releases; the forced grant does not override a lock.
- Simultaneous requests with `wait_cnt`<`MAX_WAIT`: port 0 wins and `wait_cnt` increments.
- Reset mid-read: the pending `rvalid` is dropped and `lock_q` is cleared.
- A request withdrawn before grant is legal and leaves no state, except that it clears `wait_cnt` for port 1.

## Test plan
- Reset, then reads only on port 0: read `0x10` gives `m0_gnt`=1 in the same cycle; the next cycle `m0_rvalid`=1 with `m0_rdata` = memory word at `0x10`. `m1_rvalid` stays 0.
- Both ports request continuously, `MAX_WAIT`=4, no lock: grant sequence is 0,0,0,0,1,0,0,0,0,1… and `wait_cnt` peaks at 4.
- Port 0 `lock`=1 for 3 transfers then `lock`=0, with `m1_req` constant: `m1_gnt`=0 for all 4 port-0 transfers, then `m1_gnt`=1 on the next cycle.
- Port 1 writes `0xDEADBEEF` to `0x20`, then port 0 reads `0x20` the next cycle: `mem_we`=1 for exactly one cycle, and `m0_rdata`=`0xDEADBEEF` the cycle after the read grant.
- Interleaved reads on alternate cycles (p0 `0x4`, p1 `0x8`, p0 `0xC`): `rvalid` pulses alternate with matching data, and each port's `rdata` holds between its own reads.
- Assert `reset` in the cycle after a port-1 read grant: `m1_rvalid` stays 0, all state is zero, and `gnt`=0 while reset is high.
